// File: rtl/fofb_cell_collector_if.sv
// Per-link status event bundle from the cell-link receivers into the collector.
// Each field is packed per link, link k in the k-th slice.
interface fofb_cell_collector_if #(
    parameter int unsigned N_LINKS          = 2,
    parameter int unsigned CELL_INDEX_WIDTH = 5
);
    logic [N_LINKS-1:0]                  linkInhibit;
    logic [N_LINKS-1:0]                  statusValid;
    logic [2*N_LINKS-1:0]                statusCode;
    logic [CELL_INDEX_WIDTH*N_LINKS-1:0] statusCellIndex;
    logic [N_LINKS-1:0]                  statusFOFBenabled;

    modport master (
        output linkInhibit, statusValid, statusCode, statusCellIndex, statusFOFBenabled
    );
    modport slave (
        input  linkInhibit, statusValid, statusCode, statusCellIndex, statusFOFBenabled
    );
endinterface

// File: rtl/fofb_cell_collector.sv
// FOFB cell collector: merges N_LINKS status streams into per-FA-cycle cell bitmaps and
// declares readout complete or timed out. Define FOFB_CELL_DUPLICATE_COUNT_EN for dupCount.
module fofb_cell_collector #(
    parameter int unsigned N_LINKS             = 2,
    parameter int unsigned MAX_CELLS           = 32,
    parameter int unsigned CELL_INDEX_WIDTH    = $clog2(MAX_CELLS),
    parameter int unsigned CELL_COUNT_WIDTH    = $clog2(MAX_CELLS + 1),
    parameter int unsigned SYSCLK_RATE         = 100000000,
    parameter int unsigned READOUT_TIMER_WIDTH = 5,
    parameter int unsigned SEQNO_WIDTH         = 3
) (
    input  logic                                sysClk,
    input  logic                                sysReset,
    input  logic                                FAstrobe,
    input  logic [CELL_COUNT_WIDTH-1:0]         cellCount,
    fofb_cell_collector_if.slave                status,
    output logic [MAX_CELLS-1:0]                fofbBitmapAll,
    output logic [MAX_CELLS-1:0]                fofbBitmapEnabled,
    output logic [MAX_CELLS-1:0]                fofbBitmapAllFASnapshot,
    output logic [MAX_CELLS-1:0]                fofbEnableBitmapFASnapshot,
    output logic [CELL_COUNT_WIDTH*N_LINKS-1:0] linkPacketCount,
    output logic                                readoutActive,
    output logic                                readoutValid,
    output logic                                readTimeout,
    output logic                                fofbEnabled,
    output logic                                timeoutStrobe,
    output logic [READOUT_TIMER_WIDTH-1:0]      readoutTime,
    output logic [SEQNO_WIDTH-1:0]              seqno,
    output logic [7:0]                          dupCount
);
    localparam int unsigned CLK_PER_US = SYSCLK_RATE / 1000000;
    localparam int unsigned DIV_WIDTH  = $clog2(CLK_PER_US);
    localparam logic [DIV_WIDTH-1:0] DIV_RELOAD = DIV_WIDTH'(CLK_PER_US - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_FIRST  = DIV_WIDTH'(CLK_PER_US / 2 - 1);

    typedef enum logic {StIdle, StActive} state_e;
    state_e state, stateNext;

    logic [CELL_COUNT_WIDTH-1:0]    cellCounter, fofbCounter;
    logic [CELL_COUNT_WIDTH-1:0]    linkCounter [N_LINKS];
    logic [DIV_WIDTH-1:0]           divider;
    logic [READOUT_TIMER_WIDTH-1:0] timer;
    logic                           timeoutFlag;
    logic                           complete, timeout;

    logic [CELL_INDEX_WIDTH-1:0] cellIdx [N_LINKS];
    logic [N_LINKS-1:0]          accept;
    logic [MAX_CELLS-1:0]        setAll, setEn, newAll, newEn;

    // Merge every link in one cycle; an out-of-range index sets no bit.
    always_comb begin
        accept = '0;
        setAll = '0;
        setEn  = '0;
        for (int k = 0; k < N_LINKS; k++) begin
            cellIdx[k] = status.statusCellIndex[k*CELL_INDEX_WIDTH +: CELL_INDEX_WIDTH];
            accept[k]  = (state == StActive) && !FAstrobe && status.statusValid[k] &&
                         !status.linkInhibit[k] && (status.statusCode[2*k +: 2] == 2'b00);
            if (accept[k] && (32'(cellIdx[k]) < MAX_CELLS)) begin
                setAll[cellIdx[k]] = 1'b1;
                if (status.statusFOFBenabled[k]) setEn[cellIdx[k]] = 1'b1;
            end
        end
        newAll = setAll & ~fofbBitmapAll;
        newEn  = setEn & ~fofbBitmapEnabled;
    end

    // Completion is judged on the registered counter, so it lands one cycle after the event.
    always_comb begin
        stateNext = state;
        complete  = 1'b0;
        timeout   = 1'b0;
        if (FAstrobe) begin
            stateNext = StActive;
        end else if (state == StActive) begin
            if (cellCounter == cellCount) begin
                complete  = 1'b1;
                stateNext = StIdle;
            end else if (timeoutFlag) begin
                timeout   = 1'b1;
                stateNext = StIdle;
            end
        end
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) state <= StIdle;
        else          state <= stateNext;
    end

    assign readoutActive = (state == StActive);

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            fofbBitmapAll              <= '0;
            fofbBitmapEnabled          <= '0;
            fofbBitmapAllFASnapshot    <= '0;
            fofbEnableBitmapFASnapshot <= '0;
            linkPacketCount            <= '0;
            cellCounter                <= '0;
            fofbCounter                <= '0;
            for (int k = 0; k < N_LINKS; k++) linkCounter[k] <= '0;
            divider                    <= '0;
            timer                      <= '0;
            timeoutFlag                <= 1'b0;
            readoutValid               <= 1'b0;
            readTimeout                <= 1'b0;
            fofbEnabled                <= 1'b0;
            timeoutStrobe              <= 1'b0;
            readoutTime                <= '0;
            seqno                      <= '0;
        end else begin
            timeoutStrobe <= 1'b0;
            if (FAstrobe) begin
                fofbBitmapAllFASnapshot    <= fofbBitmapAll;
                fofbEnableBitmapFASnapshot <= fofbBitmapEnabled;
                for (int k = 0; k < N_LINKS; k++) begin
                    linkPacketCount[k*CELL_COUNT_WIDTH +: CELL_COUNT_WIDTH] <= linkCounter[k];
                    linkCounter[k] <= '0;
                end
                fofbBitmapAll     <= '0;
                fofbBitmapEnabled <= '0;
                cellCounter       <= '0;
                fofbCounter       <= '0;
                readoutValid      <= 1'b0;
                readTimeout       <= 1'b0;
                timer             <= '0;
                timeoutFlag       <= 1'b0;
                divider           <= DIV_FIRST;
            end else begin
                fofbBitmapAll     <= fofbBitmapAll | setAll;
                fofbBitmapEnabled <= fofbBitmapEnabled | setEn;
                cellCounter       <= cellCounter + CELL_COUNT_WIDTH'($countones(newAll));
                fofbCounter       <= fofbCounter + CELL_COUNT_WIDTH'($countones(newEn));
                for (int k = 0; k < N_LINKS; k++) begin
                    if (accept[k] && (linkCounter[k] != '1)) linkCounter[k] <= linkCounter[k] + 1'b1;
                end
                if (state == StActive) begin
                    if (divider == '0) begin
                        divider <= DIV_RELOAD;
                        timer   <= timer + 1'b1;
                        if (timer == '1) timeoutFlag <= 1'b1;
                    end else begin
                        divider <= divider - 1'b1;
                    end
                end
                if (complete) begin
                    readoutValid <= 1'b1;
                    fofbEnabled  <= (fofbCounter == cellCount);
                    readoutTime  <= timer;
                    seqno        <= seqno + 1'b1;
                    timeoutFlag  <= 1'b0;
                end else if (timeout) begin
                    readTimeout   <= 1'b1;
                    timeoutStrobe <= 1'b1;
                    fofbEnabled   <= 1'b0;
                    readoutTime   <= timer;
                    timeoutFlag   <= 1'b0;
                end
            end
        end
    end

`ifdef FOFB_CELL_DUPLICATE_COUNT_EN
    logic [3:0]           dupInc;
    logic [MAX_CELLS-1:0] seen;
    logic [8:0]           dupSum;

    // A later link repeating an earlier link's cell in the same cycle is a duplicate.
    always_comb begin
        dupInc = '0;
        seen   = fofbBitmapAll;
        for (int k = 0; k < N_LINKS; k++) begin
            if (accept[k] && (32'(cellIdx[k]) < MAX_CELLS)) begin
                if (seen[cellIdx[k]]) dupInc = dupInc + 4'd1;
                seen[cellIdx[k]] = 1'b1;
            end
        end
        dupSum = {1'b0, dupCount} + 9'(dupInc);
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset)      dupCount <= '0;
        else if (FAstrobe) dupCount <= '0;
        else if (dupSum[8]) dupCount <= 8'hff;
        else               dupCount <= dupSum[7:0];
    end
`else
    assign dupCount = '0;
`endif

endmodule

// File: tb/tb_fofb_cell_collector.sv
// Self-checking bench for fofb_cell_collector: directed scenarios plus randomized FA cycles
// checked every cycle against a cell-set reference model.
module tb_fofb_cell_collector;
    localparam int NL   = 2;
    localparam int MC   = 32;
    localparam int CIW  = 5;
    localparam int CCW  = 6;
    localparam int RATE = 4000000;
    localparam int TW   = 3;
    localparam int SW   = 3;
    localparam int PER  = RATE / 1000000;
    localparam int HALF = PER / 2;
    localparam int TMO_AGE = HALF + ((1 << TW) - 1) * PER + 1;

    logic sysClk, sysReset, FAstrobe;
    logic [CCW-1:0] cellCount;
    logic [MC-1:0] fofbBitmapAll, fofbBitmapEnabled, fofbBitmapAllFASnapshot;
    logic [MC-1:0] fofbEnableBitmapFASnapshot;
    logic [CCW*NL-1:0] linkPacketCount;
    logic readoutActive, readoutValid, readTimeout, fofbEnabled, timeoutStrobe;
    logic [TW-1:0] readoutTime;
    logic [SW-1:0] seqno;
    logic [7:0] dupCount;

    fofb_cell_collector_if #(.N_LINKS(NL), .CELL_INDEX_WIDTH(CIW)) sif ();

    fofb_cell_collector #(
        .N_LINKS(NL), .MAX_CELLS(MC), .CELL_INDEX_WIDTH(CIW), .CELL_COUNT_WIDTH(CCW),
        .SYSCLK_RATE(RATE), .READOUT_TIMER_WIDTH(TW), .SEQNO_WIDTH(SW)
    ) dut (
        .sysClk(sysClk), .sysReset(sysReset), .FAstrobe(FAstrobe), .cellCount(cellCount),
        .status(sif),
        .fofbBitmapAll(fofbBitmapAll), .fofbBitmapEnabled(fofbBitmapEnabled),
        .fofbBitmapAllFASnapshot(fofbBitmapAllFASnapshot),
        .fofbEnableBitmapFASnapshot(fofbEnableBitmapFASnapshot),
        .linkPacketCount(linkPacketCount), .readoutActive(readoutActive),
        .readoutValid(readoutValid), .readTimeout(readTimeout), .fofbEnabled(fofbEnabled),
        .timeoutStrobe(timeoutStrobe), .readoutTime(readoutTime), .seqno(seqno),
        .dupCount(dupCount)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    int total = 0;
    int bad   = 0;

    // Reference model: cell sets, per-link tallies and age since the last FAstrobe.
    bit [MC-1:0]  mAll, mEn, mSnapAll, mSnapEn;
    logic [CCW-1:0] mLink [NL];
    logic [CCW-1:0] mLpc [NL];
    bit mActive, mValid, mTmo, mFofbEn, mTStrobe;
    int mTime, mSeq, mDup, mAge;

    function automatic int timerVal(int n);
        if (n < HALF) return 0;
        return ((n - HALF) / PER + 1) % (1 << TW);
    endfunction

    task automatic modelReset();
        mAll = '0; mEn = '0; mSnapAll = '0; mSnapEn = '0;
        for (int k = 0; k < NL; k++) begin mLink[k] = '0; mLpc[k] = '0; end
        mActive = 0; mValid = 0; mTmo = 0; mFofbEn = 0; mTStrobe = 0;
        mTime = 0; mSeq = 0; mDup = 0; mAge = 0;
    endtask

    task automatic modelEdge();
        bit wasActive;
        bit [MC-1:0] seen, addAll, addEn;
        int idx;
        if (sysReset) begin modelReset(); return; end
        mTStrobe = 0;
        if (FAstrobe) begin
            mSnapAll = mAll; mSnapEn = mEn;
            for (int k = 0; k < NL; k++) begin mLpc[k] = mLink[k]; mLink[k] = '0; end
            mAll = '0; mEn = '0; mValid = 0; mTmo = 0; mDup = 0; mAge = 0; mActive = 1;
            return;
        end
        wasActive = mActive;
        if (mActive) begin
            mAge++;
            if ($countones(mAll) == int'(cellCount)) begin
                mValid = 1; mFofbEn = ($countones(mEn) == int'(cellCount));
                mTime = timerVal(mAge - 1); mSeq++; mActive = 0;
            end else if (mAge == TMO_AGE) begin
                mTmo = 1; mTStrobe = 1; mFofbEn = 0; mTime = timerVal(mAge - 1); mActive = 0;
            end
        end
        if (!wasActive) return;
        seen = mAll; addAll = '0; addEn = '0;
        for (int k = 0; k < NL; k++) begin
            if (sif.statusValid[k] && !sif.linkInhibit[k] && sif.statusCode[2*k +: 2] == 2'd0) begin
                idx = int'(sif.statusCellIndex[k*CIW +: CIW]);
                if (mLink[k] != '1) mLink[k] = mLink[k] + 1'b1;
                if (seen[idx] && mDup < 255) mDup++;
                seen[idx] = 1'b1;
                addAll[idx] = 1'b1;
                if (sif.statusFOFBenabled[k]) addEn[idx] = 1'b1;
            end
        end
        mAll |= addAll;
        mEn  |= addEn;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        logic [7:0] expDup;
`ifdef FOFB_CELL_DUPLICATE_COUNT_EN
        expDup = 8'(mDup);
`else
        expDup = 8'd0;
`endif
        chk("readoutActive", 64'(readoutActive), 64'(mActive));
        chk("readoutValid", 64'(readoutValid), 64'(mValid));
        chk("readTimeout", 64'(readTimeout), 64'(mTmo));
        chk("fofbEnabled", 64'(fofbEnabled), 64'(mFofbEn));
        chk("timeoutStrobe", 64'(timeoutStrobe), 64'(mTStrobe));
        chk("readoutTime", 64'(readoutTime), 64'(mTime % (1 << TW)));
        chk("seqno", 64'(seqno), 64'(mSeq % (1 << SW)));
        chk("bitmapAll", 64'(fofbBitmapAll), 64'(mAll));
        chk("bitmapEnabled", 64'(fofbBitmapEnabled), 64'(mEn));
        chk("snapAll", 64'(fofbBitmapAllFASnapshot), 64'(mSnapAll));
        chk("snapEnabled", 64'(fofbEnableBitmapFASnapshot), 64'(mSnapEn));
        chk("linkPacketCount", 64'(linkPacketCount), 64'({mLpc[1], mLpc[0]}));
        chk("dupCount", 64'(dupCount), 64'(expDup));
    endtask

    task automatic step();
        @(posedge sysClk);
        modelEdge();
        #1;
        checkAll();
        FAstrobe = 1'b0;
        sif.statusValid = '0;
    endtask

    task automatic ev(input int k, input int idx, input bit en, input int code);
        sif.statusValid[k] = 1'b1;
        sif.statusCellIndex[k*CIW +: CIW] = CIW'(idx);
        sif.statusFOFBenabled[k] = en;
        sif.statusCode[2*k +: 2] = 2'(code);
    endtask

    task automatic strobe();
        FAstrobe = 1'b1;
        step();
    endtask

    initial begin
        int first, pulses;
        int len;
        modelReset();
        sysReset = 1'b1; FAstrobe = 1'b0; cellCount = '0;
        sif.linkInhibit = '0; sif.statusValid = '0; sif.statusCode = '0;
        sif.statusCellIndex = '0; sif.statusFOFBenabled = '0;

        // Reset state
        step(); step();
        chk("rst_active", 64'(readoutActive), 64'd0);
        chk("rst_seqno", 64'(seqno), 64'd0);
        sysReset = 1'b0;
        step();

        // Basic completion: three cells over two links
        cellCount = 6'd3;
        strobe();
        ev(0, 0, 1, 0); ev(1, 2, 1, 0); step();
        ev(0, 1, 1, 0); step();
        chk("basic_valid_early", 64'(readoutValid), 64'd0);
        step();
        chk("basic_valid", 64'(readoutValid), 64'd1);
        chk("basic_fofbEn", 64'(fofbEnabled), 64'd1);
        chk("basic_seqno", 64'(seqno), 64'd1);
        chk("basic_all", 64'(fofbBitmapAll), 64'h7);
        chk("basic_en", 64'(fofbBitmapEnabled), 64'h7);

        // Simultaneous duplicate
        cellCount = 6'd2;
        strobe();
        chk("dup_snap", 64'(fofbBitmapAllFASnapshot), 64'h7);
        chk("dup_lpc", 64'(linkPacketCount), 64'((1 << CCW) | 2));
        ev(0, 5, 1, 0); ev(1, 5, 1, 0); step();
        step(); step();
        chk("dup_no_complete", 64'(readoutValid), 64'd0);
        chk("dup_all", 64'(fofbBitmapAll), 64'h20);
`ifdef FOFB_CELL_DUPLICATE_COUNT_EN
        chk("dup_count", 64'(dupCount), 64'd1);
`else
        chk("dup_count", 64'(dupCount), 64'd0);
`endif

        // Partially enabled
        cellCount = 6'd2;
        strobe();
        ev(0, 0, 1, 0); ev(1, 1, 0, 0); step();
        step();
        chk("part_valid", 64'(readoutValid), 64'd1);
        chk("part_fofbEn", 64'(fofbEnabled), 64'd0);
        chk("part_en", 64'(fofbBitmapEnabled), 64'h1);

        // Timeout: strobe sampled at edge 1, pulse expected after edge 32
        cellCount = 6'd4;
        strobe();
        first = 0; pulses = 0;
        for (int i = 2; i <= 60; i++) begin
            if (i == 2) begin ev(0, 0, 1, 0); ev(1, 1, 1, 0); end
            if (i == 3) ev(0, 2, 1, 0);
            step();
            if (timeoutStrobe) begin
                pulses++;
                if (first == 0) first = i;
                chk("tmo_readTimeout", 64'(readTimeout), 64'd1);
                chk("tmo_time", 64'(readoutTime), 64'd0);
                chk("tmo_valid", 64'(readoutValid), 64'd0);
            end
        end
        chk("tmo_edge", 64'(first), 64'd32);
        chk("tmo_pulses", 64'(pulses), 64'd1);

        // Inhibit and error codes
        sif.linkInhibit = 2'b10;
        cellCount = 6'd5;
        strobe();
        for (int i = 0; i < 4; i++) begin
            ev(1, i, 1, 0); ev(0, i + 8, 1, 2); step();
        end
        chk("inh_all", 64'(fofbBitmapAll), 64'd0);
        strobe();
        chk("inh_lpc", 64'(linkPacketCount), 64'd0);
        sif.linkInhibit = 2'b00;

        // FAstrobe coincident with an event
        cellCount = 6'd5;
        strobe();
        ev(0, 3, 1, 0); step();
        FAstrobe = 1'b1; ev(0, 4, 1, 0); step();
        chk("coinc_snap", 64'(fofbBitmapAllFASnapshot), 64'h8);
        chk("coinc_all", 64'(fofbBitmapAll), 64'd0);
        step();
        chk("coinc_all_after", 64'(fofbBitmapAll), 64'd0);

        // Reset mid-ACTIVE
        ev(1, 6, 1, 0); step();
        sysReset = 1'b1;
        #2;
        chk("arst_active", 64'(readoutActive), 64'd0);
        chk("arst_all", 64'(fofbBitmapAll), 64'd0);
        chk("arst_snap", 64'(fofbBitmapAllFASnapshot), 64'd0);
        step();
        sysReset = 1'b0;
        ev(0, 7, 1, 0); step();
        step();
        chk("arst_ignored", 64'(fofbBitmapAll), 64'd0);

        // Randomized FA cycles, including cellCount beyond MAX_CELLS
        for (int p = 0; p < 16; p++) begin
            cellCount = ($urandom_range(0, 7) == 0) ? 6'd33 : 6'($urandom_range(0, 6));
            sif.linkInhibit = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            len = $urandom_range(3, 40);
            for (int c = 0; c < len; c++) begin
                if (c == 0) FAstrobe = 1'b1;
                for (int k = 0; k < NL; k++) begin
                    if ($urandom_range(0, 2) != 0)
                        ev(k, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                           ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
                end
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fofb_cell_collector.md
# fofb_cell_collector

Parametrised successor to the two-link FOFB cell tracker. It accepts per-cell status events from `N_LINKS` cell-link receivers, already in the system clock domain, with one event per link per cycle. All links are merged in the same cycle with no arbiter or FIFO. Each FA cycle it tracks received and FOFB-enabled cells, then declares the readout valid or timed out. It sits between the link receivers and the DSP readout / microBlaze CSR.

## Interface
- `N_LINKS`, 2: number of status inputs, 1..8.
- `MAX_CELLS`, 32: bitmap width.
- `CELL_INDEX_WIDTH`, `$clog2(MAX_CELLS)`: cell index width.
- `CELL_COUNT_WIDTH`, `$clog2(MAX_CELLS+1)`: counter width.
- `SYSCLK_RATE`, 100000000: Hz; `SYSCLK_RATE/1000000` ≥ 2.
- `READOUT_TIMER_WIDTH`, 5: µs timer width; timeout = 2^W µs.
- `SEQNO_WIDTH`, 3: completed-readout sequence number width.
- `sysClk` in 1: sole clock.
- `sysReset` in 1: asynchronous, active-high reset.
- `FAstrobe` in 1: one-cycle start of FA cycle.
- `cellCount` in CELL_COUNT_WIDTH: expected cells; sampled every cycle.
- `linkInhibit` in N_LINKS: per-link ignore.
- `statusValid` in N_LINKS: event strobe per link.
- `statusCode` in 2·N_LINKS: per link; 0 = success.
- `statusCellIndex` in CELL_INDEX_WIDTH·N_LINKS: per link.
- `statusFOFBenabled` in N_LINKS: per link.
- `fofbBitmapAll`, `fofbBitmapEnabled` out MAX_CELLS: live bitmaps.
- `fofbBitmapAllFASnapshot`, `fofbEnableBitmapFASnapshot` out MAX_CELLS: bitmaps latched at `FAstrobe`.
- `linkPacketCount` out CELL_COUNT_WIDTH·N_LINKS: accepted successes per link in the previous FA cycle; saturating.
- `readoutActive`, `readoutValid`, `readTimeout`, `fofbEnabled` out 1: readout state.
- `timeoutStrobe` out 1: one-cycle pulse on timeout.
- `readoutTime` out READOUT_TIMER_WIDTH: timer value at completion or timeout.
- `seqno` out SEQNO_WIDTH: increments on each valid completion.
- `dupCount` out 8: see Configuration.

## Operation
- **Reset.** Every output is 0, including bitmaps, snapshots, counts, `seqno` and `dupCount`. The state machine enters IDLE.
- **States.**
  - IDLE: `readoutActive`=0.
  - ACTIVE: `readoutActive`=1.
- **FAstrobe, from any state.**
  - Latches both snapshots from the live bitmaps.
  - Latches `linkPacketCount` from the internal per-link counters, then clears those counters.
  - Clears the live bitmaps, the cell/fofb counters, `readoutValid`, `readTimeout` and the timer.
  - Loads the µs divider with `(SYSCLK_RATE/1e6)/2 − 1`.
  - Enters ACTIVE.
  - Status events in the same cycle are discarded.
- **Event acceptance.** An event on link k is accepted only in ACTIVE, when `statusValid[k]` = 1, `linkInhibit[k]` = 0 and `statusCode` = 0. Each accepted event increments link k's internal counter, saturating at all-ones.
- **Merging links within a cycle.**
  - Form a one-hot set of all accepted cell indices; set E holds the indices whose accepted event also has FOFB enabled.
  - `fofbBitmapAll` |= the set.
  - `cellCounter` += popcount(set & ~`fofbBitmapAll`).
  - The same rule applies to `fofbBitmapEnabled`/`fofbCounter` using set E.
  - Two links reporting the same new cell in one cycle count once.
- **Completion (ACTIVE).** When `cellCounter` == `cellCount`, in the cycle after the update that reached it:
  - `readoutValid` ← 1, `fofbEnabled` ← (`fofbCounter` == `cellCount`).
  - `readoutTime` ← timer, `seqno` += 1 (wraps).
  - Go to IDLE.
- **Timeout (ACTIVE).**
  - The µs tick fires when the divider reaches 0. The divider then reloads with `SYSCLK_RATE/1e6 − 1` and the timer increments, wrapping.
  - A tick with the timer all-ones sets `timeoutFlag`.
  - The next cycle, if not complete: `readTimeout` ← 1, `timeoutStrobe` pulses, `fofbEnabled` ← 0, `readoutTime` ← timer, go to IDLE.
- **Priorities.**
  - `FAstrobe` beats everything.
  - Completion beats timeout in the same cycle.
- **`cellCount` = 0.** The readout completes in the first cycle after `FAstrobe` with `fofbEnabled` = 1.
- **`cellCount` > `MAX_CELLS`.** The readout always times out.
- **Reset mid-ACTIVE.** Returns to IDLE with all outputs 0. Events are ignored until the next `FAstrobe`.

## Timing
- Event → bitmap bit and counter: 1 cycle.
- Counter reaching `cellCount` → `readoutValid`: 1 further cycle.
- `FAstrobe` → `readoutActive` and snapshots: 1 cycle.
- Timeout fires `FAstrobe` + 1 + (SYSCLK_RATE/1e6)/2 + (2^W − 1)·(SYSCLK_RATE/1e6) + 1 cycles after `FAstrobe`.
- All outputs are registered.

## Configuration
- **`FOFB_CELL_DUPLICATE_COUNT_EN` defined.** `dupCount` counts events that are accepted but whose cell bit was already set before this cycle, or that duplicate another link's cell in the same cycle. It increments by the number of such events, saturates at 255, and clears on `FAstrobe`.
- **Undefined.** `dupCount` is tied to 0 and no counter logic is synthesised.

## Test plan
- **Basic completion.**
  - Stimulus: N_LINKS=2, cellCount=3; link0 sends cells 0 and 1, link1 sends cell 2, all enabled.
  - Expect: `readoutValid`=1 and `fofbEnabled`=1 one cycle after the third event; `seqno`=1; bitmaps = 0x7.
- **Simultaneous duplicate.**
  - Stimulus: both links send cell 5 in the same cycle; cellCount=2.
  - Expect: `cellCounter`=1 and no completion; with the macro defined, `dupCount`=1.
- **Partially enabled.**
  - Stimulus: cellCount=2, cell 1 has FOFB disabled.
  - Expect: `readoutValid`=1, `fofbEnabled`=0, `fofbBitmapEnabled`=0x1.
- **Timeout.**
  - Stimulus: SYSCLK_RATE=4 MHz, W=3, cellCount=4, only 3 cells sent.
  - Expect: `timeoutStrobe` one pulse exactly 32 cycles after `FAstrobe`; `readTimeout`=1; `readoutTime`=0; `readoutValid`=0.
- **Inhibit and error codes.**
  - Stimulus: `linkInhibit`=0b10; link1 success events; link0 events with code 2.
  - Expect: no bitmap bits set; after the next `FAstrobe`, `linkPacketCount` = 0 for both links.
- **FAstrobe edge cases.**
  - Stimulus: `FAstrobe` coincides with an event; separately, assert `sysReset` mid-ACTIVE.
  - Expect: the coincident event is dropped; the snapshot holds the prior bitmap; after reset all outputs are 0.
